rx_serial_7e1: RTL and testbench

Asynchronous serial receiver for 7-bit ASCII frames in 7E1 format: 1 start bit, 7 data bits LSB first, even parity, 1 stop bit. It is the receive-side counterpart of the 7E1 transmitter in the sensor datapath. It lets the host send command characters (for example measurement requests) into the system over the same serial link that carries the ASCII distance readings. The block samples each bit at mid-bit, checks parity and stop, and presents the decoded character with a one-cycle `pronto` pulse.

---
 rtl/rx_serial_7e1.sv | 129 ++++++++++++
 tb/tb_rx_serial_7e1.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rx_serial_7e1.sv
// rx_serial_7e1: asynchronous serial receiver for 7E1 frames.
// Frame format: one start bit, 7 data bits LSB first, even parity, one stop bit.
// Each bit is sampled at mid-bit. The decoded character is presented with a
// one-cycle pronto pulse.
//
// Parameters:
//   M - clock cycles per bit (even, >= 4)
//   N - bit-timer width (2^N > M)
// Ports:
//   clock          system clock
//   reset          synchronous, active-high reset
//   entrada_serial serial line, idle high, asynchronous to clock
//   dados_ascii    last received character
//   pronto         one-cycle pulse when a frame completes
//   paridade_ok    last frame had correct even parity
//   erro_stop      last frame's stop bit was sampled as 0
//   db_estado      current FSM state code (debug)
module rx_serial_7e1 #(
  parameter int M = 434,
  parameter int N = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       paridade_ok,
  output logic       erro_stop,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    st_inicial        = 4'd0,
    st_espera         = 4'd1,
    st_confirma_start = 4'd2,
    st_recebe         = 4'd3,
    st_armazena       = 4'd4,
    st_final          = 4'd5,
    st_aguarda_idle   = 4'd6
  } state_t;

  localparam logic [N-1:0] HALF_END = N'(M/2 - 1);
  localparam logic [N-1:0] BIT_END  = N'(M - 1);

  state_t       state, next_state;
  logic         sync1, rx;
  logic [N-1:0] timer;
  logic [3:0]   bit_idx;
  logic [6:0]   data_reg;
  logic         parity_bit, stop_bit;
  logic         tick_half, tick_bit;

  // Two-flop synchronizer; flops idle high so reset does not look like a start bit
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= entrada_serial;
      rx    <= sync1;
    end
  end

  assign tick_half = (timer == HALF_END);
  assign tick_bit  = (timer == BIT_END);

  always_ff @(posedge clock) begin
    if (reset) state <= st_inicial;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      st_inicial:        next_state = st_espera;
      st_espera:         if (!rx) next_state = st_confirma_start;
      st_confirma_start: if (tick_half) next_state = rx ? st_espera : st_recebe;
      st_recebe:         if (tick_bit && bit_idx == 4'd8) next_state = st_armazena;
      st_armazena:       next_state = st_final;
      // A low stop bit may be a break; wait for idle before hunting for a start
      st_final:          next_state = stop_bit ? st_espera : st_aguarda_idle;
      st_aguarda_idle:   if (rx) next_state = st_espera;
      default:           next_state = st_inicial;
    endcase
  end

  assign pronto    = (state == st_final);
  assign db_estado = state;

  // Bit timer, shift register and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      timer       <= '0;
      bit_idx     <= '0;
      data_reg    <= '0;
      parity_bit  <= 1'b0;
      stop_bit    <= 1'b0;
      dados_ascii <= '0;
      paridade_ok <= 1'b0;
      erro_stop   <= 1'b0;
    end else begin
      case (state)
        st_confirma_start: begin
          timer   <= tick_half ? '0 : timer + 1'b1;
          bit_idx <= '0;
        end
        st_recebe: begin
          if (tick_bit) begin
            timer   <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx < 4'd7)       data_reg   <= {rx, data_reg[6:1]};
            else if (bit_idx == 4'd7) parity_bit <= rx;
            else                      stop_bit   <= rx;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        st_armazena: begin
          dados_ascii <= data_reg;
          paridade_ok <= ~(^data_reg ^ parity_bit);
          erro_stop   <= ~stop_bit;
          timer       <= '0;
        end
        default: timer <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Bench for rx_serial_7e1 with M=16, N=5. Frames are driven on the pin as bit
// sequences; a queue holds the character, parity/stop flags and pronto cycle
// each completed frame must produce.
module tb_rx_serial_7e1;
  localparam int M = 16;
  localparam int N = 5;
  localparam int LAT = 2 + M/2 + 9*M + 2;   // pin fall to pronto, in cycles

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       entrada_serial = 1'b1;
  logic [6:0] dados_ascii;
  logic       pronto, paridade_ok, erro_stop;
  logic [3:0] db_estado;

  rx_serial_7e1 #(.M(M), .N(N)) dut (
    .clock(clock), .reset(reset), .entrada_serial(entrada_serial),
    .dados_ascii(dados_ascii), .pronto(pronto), .paridade_ok(paridade_ok),
    .erro_stop(erro_stop), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [6:0] d;
    logic       pok;
    logic       serr;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   pcyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dados"}, dados_ascii, 0);
    chk({tag, "_pronto"}, pronto, 0);
    chk({tag, "_pok"}, paridade_ok, 0);
    chk({tag, "_serr"}, erro_stop, 0);
  endtask

  // Drives one frame. abort_at >= 0 pulses reset in the middle of that data bit.
  task automatic send_frame(input logic [6:0] d, input logic pbit, input logic sbit,
                            input int abort_at);
    logic [9:0] bits;
    exp_t e;
    bits = {sbit, pbit, d, 1'b0};
    if (abort_at < 0) begin
      e.d    = d;
      e.pok  = (($countones(d) % 2) == int'(pbit));
      e.serr = !sbit;
      e.at   = cyc + LAT;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      entrada_serial = bits[i];
      if (abort_at >= 0 && i == abort_at + 1) begin
        tick(M/2);
        reset = 1'b1;
        tick(1);
        chk_zero("midreset");
        chk("midreset_state", db_estado, 0);
        reset = 1'b0;
        entrada_serial = 1'b1;
        tick(3*M);
        return;
      end
      tick(M);
    end
  endtask

  // Every pronto must match the head of the expectation queue
  initial forever begin
    @(posedge clock);
    #1;
    if (pronto !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pronto", pronto, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pronto_cycle", cyc, e.at);
        chk("dados", dados_ascii, e.d);
        chk("paridade_ok", paridade_ok, e.pok);
        chk("erro_stop", erro_stop, e.serr);
        pcyc.push_back(cyc);
      end
    end
  end

  initial begin
    int c0;
    logic [6:0] d;
    tick(3);
    chk_zero("reset");
    chk("reset_state", db_estado, 0);
    reset = 1'b0;
    tick(1);
    chk("state_espera", db_estado, 1);
    tick(30);
    chk("idle_state", db_estado, 1);
    chk_zero("idle");

    send_frame(7'h41, 1'b0, 1'b1, -1);
    send_frame(7'h43, 1'b1, 1'b1, -1);
    send_frame(7'h35, 1'b0, 1'b1, -1);
    tick(10);
    send_frame(7'h43, 1'b0, 1'b1, -1);
    tick(20);
    chk("hold_dados", dados_ascii, 7'h43);
    chk("hold_pok", paridade_ok, 0);

    // Stop bit low, line stays low afterwards
    send_frame(7'h41, 1'b0, 1'b0, -1);
    tick(32);
    chk("break_state", db_estado, 6);
    chk("break_serr_hold", erro_stop, 1);
    tick(32);
    chk("break_state2", db_estado, 6);
    entrada_serial = 1'b1;
    tick(4);
    chk("break_recover", db_estado, 1);
    tick(20);

    // Four-cycle glitch
    c0 = cyc;
    entrada_serial = 1'b0;
    tick(4);
    entrada_serial = 1'b1;
    tick(c0 + 10 - cyc);
    chk("glitch_confirm", db_estado, 2);
    tick(1);
    chk("glitch_back", db_estado, 1);
    chk("glitch_dados_hold", dados_ascii, 7'h41);
    tick(20);

    send_frame(7'h52, 1'b1, 1'b1, 3);
    chk_zero("after_abort");
    send_frame(7'h41, 1'b0, 1'b1, -1);

    for (int k = 0; k < 6; k++) begin
      d = 7'($urandom_range(0, 127));
      send_frame(d, 1'($urandom_range(0, 1)), 1'b1, -1);
      tick($urandom_range(0, 20));
    end

    tick(200);
    chk("pending_frames", exp_q.size(), 0);
    chk("pronto_count", pcyc.size(), 12);
    if (pcyc.size() >= 3) chk("back_to_back_gap", pcyc[2] - pcyc[1], 160);
    else chk("back_to_back_seen", pcyc.size(), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
